// File: rtl/pool_unit.sv
// pool_unit: collects int8 samples from SA_N lanes into an SA_N x SA_N
// scratch tile, finds the first complete FILTER_H x FILTER_W window
// (row-major), reduces it by signed max or rounded average, and queues the
// result in a first-word-fall-through FIFO.
//
// Handshake: out_valid/out_ready. A FIFO entry is transferred on every rising
// clk edge where out_valid and out_ready are both 1. out_valid never depends
// on out_ready, and the head entry stays stable until it is transferred.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   clear               synchronous flush of valid map, FIFO and overrun
//   pool_mode           0 = max, 1 = rounded average
//   pos_row, pos_col    tile base coordinate
//   in_valid/row/col/data  per-lane sample and its absolute coordinate
//   out_valid, out_ready   FIFO head handshake
//   out_row, out_col    coordinate of the window's top-left sample
//   out_data            pooled value
//   overrun             sticky: a sample landed on an already-valid cell
//   idle                no valid scratch cell and FIFO empty
module pool_unit #(
  parameter int SA_N       = 4,
  parameter int MAX_N      = 512,
  parameter int N_BITS     = $clog2(MAX_N + 1),
  parameter int FILTER_H   = 2,
  parameter int FILTER_W   = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         clear,
  input  logic                         pool_mode,
  input  logic [N_BITS-1:0]            pos_row,
  input  logic [N_BITS-1:0]            pos_col,
  input  logic [SA_N-1:0]              in_valid,
  input  logic [SA_N-1:0][N_BITS-1:0]  in_row,
  input  logic [SA_N-1:0][N_BITS-1:0]  in_col,
  input  logic [SA_N-1:0][7:0]         in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [N_BITS-1:0]            out_row,
  output logic [N_BITS-1:0]            out_col,
  output logic signed [7:0]            out_data,
  output logic                         overrun,
  output logic                         idle
);

  localparam int LOG_N  = $clog2(SA_N);
  localparam int CELL_W = $clog2(SA_N * SA_N);
  localparam int WIN_R  = SA_N / FILTER_H;
  localparam int WIN_C  = SA_N / FILTER_W;
  localparam int S      = $clog2(FILTER_H * FILTER_W);
  localparam int SUM_W  = 8 + S;
  // Half of the divisor for round-half-up; 0 for a 1x1 window.
  localparam int RND    = (1 << S) >> 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int ENT_W  = 2 * N_BITS + 8;

  logic signed [7:0]       data_q [SA_N][SA_N];
  logic signed [7:0]       data_d [SA_N][SA_N];
  logic [SA_N*SA_N-1:0]    valid_q, valid_d;
  logic                    overrun_q, overrun_d;
  logic [ENT_W-1:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wptr_q, rptr_q;
  logic [PTR_W:0]          count_q, count_d;

  logic                    found, emit, pop, full;
  logic [LOG_N-1:0]        sel_wr, sel_wc;
  logic                    all_v;
  logic [LOG_N-1:0]        ri, ci;
  logic signed [7:0]       max_v, cell_v, avg_v, win_data;
  logic signed [SUM_W-1:0] sum_v, rnd_v;
  logic [N_BITS-1:0]       win_row, win_col;
  logic [LOG_N-1:0]        lr, lc;
  logic                    ovr_hit;
  logic [ENT_W-1:0]        head;

  // Window scan: iterate in reverse so the last hit is the row-major first.
  always_comb begin
    found  = 1'b0;
    sel_wr = '0;
    sel_wc = '0;
    all_v  = 1'b0;
    for (int r = WIN_R - 1; r >= 0; r--) begin
      for (int c = WIN_C - 1; c >= 0; c--) begin
        all_v = 1'b1;
        for (int i = 0; i < FILTER_H; i++) begin
          for (int j = 0; j < FILTER_W; j++) begin
            all_v = all_v & valid_q[CELL_W'((r * FILTER_H + i) * SA_N + c * FILTER_W + j)];
          end
        end
        if (all_v) begin
          found  = 1'b1;
          sel_wr = LOG_N'(r);
          sel_wc = LOG_N'(c);
        end
      end
    end
  end

  // Reduction of the selected window (uses the registered, pre-write data).
  always_comb begin
    ri     = '0;
    ci     = '0;
    cell_v = '0;
    sum_v  = '0;
    max_v  = data_q[LOG_N'(int'(sel_wr) * FILTER_H)][LOG_N'(int'(sel_wc) * FILTER_W)];
    for (int i = 0; i < FILTER_H; i++) begin
      for (int j = 0; j < FILTER_W; j++) begin
        ri     = LOG_N'(int'(sel_wr) * FILTER_H + i);
        ci     = LOG_N'(int'(sel_wc) * FILTER_W + j);
        cell_v = data_q[ri][ci];
        if (cell_v > max_v) max_v = cell_v;
        sum_v  = sum_v + SUM_W'(cell_v);
      end
    end
    rnd_v    = sum_v + SUM_W'(RND);
    avg_v    = 8'(rnd_v >>> S);
    win_data = pool_mode ? avg_v : max_v;
  end

  assign win_row = pos_row + N_BITS'(int'(sel_wr) * FILTER_H);
  assign win_col = pos_col + N_BITS'(int'(sel_wc) * FILTER_W);

  assign pop  = out_valid & out_ready;
  assign full = (count_q == (PTR_W + 1)'(FIFO_DEPTH));
  // A full FIFO still accepts a push when its head leaves in the same cycle.
  assign emit = found & ~clear & (~full | pop);

  // Scratch next state: emit clears the window first, then lane writes land,
  // so a sample hitting the emitting window leaves its cell valid.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ovr_hit = 1'b0;
    lr      = '0;
    lc      = '0;
    if (emit) begin
      for (int i = 0; i < FILTER_H; i++) begin
        for (int j = 0; j < FILTER_W; j++) begin
          valid_d[CELL_W'((int'(sel_wr) * FILTER_H + i) * SA_N + int'(sel_wc) * FILTER_W + j)] = 1'b0;
        end
      end
    end
    // Ascending lane order: the highest lane wins a same-cell collision.
    for (int l = 0; l < SA_N; l++) begin
      if (in_valid[l]) begin
        lr = LOG_N'(in_row[l] - pos_row);
        lc = LOG_N'(in_col[l] - pos_col);
        if (valid_q[{lr, lc}]) ovr_hit = 1'b1;
        valid_d[{lr, lc}] = 1'b1;
        data_d[lr][lc]    = in_data[l];
      end
    end
    if (clear) begin
      valid_d = '0;
      ovr_hit = 1'b0;
    end
    overrun_d = ~clear & (overrun_q | ovr_hit);
  end

  always_comb begin
    count_d = count_q;
    case ({emit, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q   <= '0;
      overrun_q <= 1'b0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
    end else begin
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      if (clear) begin
        wptr_q  <= '0;
        rptr_q  <= '0;
        count_q <= '0;
      end else begin
        if (emit) wptr_q <= wptr_q + 1'b1;
        if (pop)  rptr_q <= rptr_q + 1'b1;
        count_q <= count_d;
      end
    end
  end

  // Scratch data and FIFO storage carry no reset; valid bits and count guard them.
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  always_ff @(posedge clk) begin
    if (emit) fifo_mem[wptr_q] <= {win_row, win_col, win_data};
  end

  assign head      = fifo_mem[rptr_q];
  assign out_valid = (count_q != '0);
  // Outputs read zero while empty, so stale storage never shows.
  assign out_row   = out_valid ? head[ENT_W-1 -: N_BITS] : '0;
  assign out_col   = out_valid ? head[8 +: N_BITS] : '0;
  assign out_data  = out_valid ? head[7:0] : '0;
  assign overrun   = overrun_q;
  assign idle      = (valid_q == '0) && (count_q == '0);

endmodule

// File: tb/tb_pool_unit.sv
module tb_pool_unit;
  localparam int SA_N   = 4;
  localparam int N_BITS = 10;
  localparam int DEPTH  = 4;
  localparam int EW     = 2 * N_BITS + 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  logic                        clear, pool_mode, out_ready;
  logic [N_BITS-1:0]           pos_row, pos_col;
  logic [SA_N-1:0]             in_valid;
  logic [SA_N-1:0][N_BITS-1:0] in_row, in_col;
  logic [SA_N-1:0][7:0]        in_data;
  logic                        out_valid, overrun, idle;
  logic [N_BITS-1:0]           out_row, out_col;
  logic signed [7:0]           out_data;

  pool_unit #(
    .SA_N(SA_N), .MAX_N(512), .N_BITS(N_BITS),
    .FILTER_H(2), .FILTER_W(2), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .pool_mode(pool_mode),
    .pos_row(pos_row), .pos_col(pos_col),
    .in_valid(in_valid), .in_row(in_row), .in_col(in_col), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_row(out_row), .out_col(out_col), .out_data(out_data),
    .overrun(overrun), .idle(idle)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Scratch tile as plain int arrays, output FIFO as the expected queue.
  logic [EW-1:0] exp_q[$];
  int m_valid [4][4];
  int m_data  [4][4];
  int m_old   [4][4];
  bit m_ovr;
  bit m_found, m_pop;
  int m_fr, m_fc, m_res, m_r, m_c;
  int vals [4];

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Mean rounded half up.
  function automatic int avg4(input int a, input int b, input int c, input int d);
    real x;
    x = $floor((a + b + c + d) / 4.0 + 0.5);
    return int'(x);
  endfunction

  function automatic bit model_idle();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (m_valid[r][c] != 0) return 1'b0;
    return exp_q.size() == 0;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) m_valid[r][c] = 0;
    exp_q.delete();
    m_ovr = 1'b0;
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      model_reset();
    end else if (clear) begin
      model_reset();
    end else begin
      m_old   = m_valid;
      m_pop   = (exp_q.size() > 0) && out_ready;
      m_found = 1'b0;
      m_fr    = 0;
      m_fc    = 0;
      for (int wr = 0; wr < 2; wr++)
        for (int wc = 0; wc < 2; wc++)
          if (!m_found && m_valid[2*wr][2*wc] != 0 && m_valid[2*wr][2*wc+1] != 0 &&
              m_valid[2*wr+1][2*wc] != 0 && m_valid[2*wr+1][2*wc+1] != 0) begin
            m_found = 1'b1;
            m_fr    = wr;
            m_fc    = wc;
          end
      if (m_pop) void'(exp_q.pop_front());
      if (m_found && exp_q.size() < DEPTH) begin
        for (int k = 0; k < 4; k++) vals[k] = m_data[2*m_fr + k/2][2*m_fc + k%2];
        m_res = pool_mode ? avg4(vals[0], vals[1], vals[2], vals[3])
                          : max4(vals[0], vals[1], vals[2], vals[3]);
        exp_q.push_back({N_BITS'(int'(pos_row) + 2*m_fr), N_BITS'(int'(pos_col) + 2*m_fc), 8'(m_res)});
        for (int k = 0; k < 4; k++) m_valid[2*m_fr + k/2][2*m_fc + k%2] = 0;
      end
      for (int l = 0; l < SA_N; l++) begin
        if (in_valid[l]) begin
          m_r = (int'(in_row[l]) - int'(pos_row)) & 3;
          m_c = (int'(in_col[l]) - int'(pos_col)) & 3;
          if (m_old[m_r][m_c] != 0) m_ovr = 1'b1;
          m_valid[m_r][m_c] = 1;
          m_data[m_r][m_c]  = int'($signed(in_data[l]));
        end
      end
    end
  end

  // ---------------- scoreboard compare, every cycle ----------------
  logic [EW-1:0] m_head;
  always @(negedge clk) begin
    check("cmp_out_valid", int'(out_valid), int'(exp_q.size() > 0));
    if (exp_q.size() > 0) begin
      m_head = exp_q[0];
      check("cmp_out_row", int'(out_row), int'(m_head[EW-1 -: N_BITS]));
      check("cmp_out_col", int'(out_col), int'(m_head[8 +: N_BITS]));
      check("cmp_out_data", int'(out_data), int'($signed(m_head[7:0])));
    end
    check("cmp_overrun", int'(overrun), int'(m_ovr));
    check("cmp_idle", int'(idle), int'(model_idle()));
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    in_valid = '0;
  endtask

  task automatic set_lane(input int l, input int r, input int c, input int d);
    in_valid[l] = 1'b1;
    in_row[l]   = N_BITS'(r);
    in_col[l]   = N_BITS'(c);
    in_data[l]  = 8'(d);
  endtask

  task automatic write_row(input int r, input int d0, input int d1, input int d2, input int d3);
    set_lane(0, int'(pos_row) + r, int'(pos_col) + 0, d0);
    set_lane(1, int'(pos_row) + r, int'(pos_col) + 1, d1);
    set_lane(2, int'(pos_row) + r, int'(pos_col) + 2, d2);
    set_lane(3, int'(pos_row) + r, int'(pos_col) + 3, d3);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  int seq_d [8] = '{-1, 127, 2, -128, 6, 0, 0, 3};
  int seq_r [8] = '{0, 0, 2, 2, 0, 0, 2, 2};
  int seq_c [8] = '{0, 2, 0, 2, 0, 2, 0, 2};

  // ---------------- directed tests ----------------
  initial begin
    clear = 1'b0; pool_mode = 1'b0; out_ready = 1'b0;
    pos_row = '0; pos_col = '0;
    in_valid = '0; in_row = '0; in_col = '0; in_data = '0;
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_idle", int'(idle), 1);
    check("rst_overrun", int'(overrun), 0);
    check("rst_out_data", int'(out_data), 0);
    reset_n = 1'b1;
    step();

    // Max mode, two windows, latency and idle return.
    write_row(0, 1, 5, -3, 2);
    write_row(1, 7, -8, 4, 4);
    check("max_lat_not_yet", int'(out_valid), 0);
    step();
    check("max_lat_valid", int'(out_valid), 1);
    check("max_w0_data", int'(out_data), 7);
    check("max_w0_row", int'(out_row), 0);
    check("max_w0_col", int'(out_col), 0);
    step();
    out_ready = 1'b1;
    step();
    check("max_w1_data", int'(out_data), 4);
    check("max_w1_col", int'(out_col), 2);
    step();
    check("max_empty", int'(out_valid), 0);
    check("max_idle", int'(idle), 1);
    out_ready = 1'b0;

    // Average mode, FIFO fills to depth, then a second tile is held.
    pool_mode = 1'b1;
    write_row(0, -1, -1, 127, 127);
    write_row(1, -1, -2, 127, 127);
    write_row(2, 1, 2, -128, -128);
    write_row(3, 1, 2, -128, -128);
    repeat (3) step();
    write_row(0, 4, 8, 0, 0);
    write_row(1, 4, 8, 1, 0);
    write_row(2, 10, -10, 3, 3);
    write_row(3, 10, -10, 3, 3);
    repeat (3) step();
    check("bp_held_valid", int'(out_valid), 1);
    check("bp_held_head", int'(out_data), -1);
    check("bp_not_idle", int'(idle), 0);
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("bp_seq%0d_data", k), int'(out_data), seq_d[k]);
      check($sformatf("bp_seq%0d_row", k), int'(out_row), seq_r[k]);
      check($sformatf("bp_seq%0d_col", k), int'(out_col), seq_c[k]);
      step();
    end
    check("bp_drained", int'(out_valid), 0);
    out_ready = 1'b0;
    pool_mode = 1'b0;

    // Priority: windows (0,1) and (1,1) complete together, nonzero base.
    pos_row = N_BITS'(100);
    pos_col = N_BITS'(200);
    set_lane(0, 100, 202, 9);  set_lane(1, 100, 203, 1);
    set_lane(2, 102, 202, -5); set_lane(3, 102, 203, -6);
    step();
    set_lane(0, 101, 202, 2);  set_lane(1, 101, 203, 3);
    set_lane(2, 103, 202, -7); set_lane(3, 103, 203, -8);
    step();
    step();
    check("pri_first_row", int'(out_row), 100);
    check("pri_first_col", int'(out_col), 202);
    check("pri_first_data", int'(out_data), 9);
    step();
    out_ready = 1'b1;
    step();
    check("pri_second_row", int'(out_row), 102);
    check("pri_second_col", int'(out_col), 202);
    check("pri_second_data", int'(out_data), -5);
    step();
    out_ready = 1'b0;
    check("pri_idle", int'(idle), 1);

    // Overrun: same cell written twice, then clear.
    pos_row = '0;
    pos_col = '0;
    set_lane(0, 0, 0, 3);
    step();
    check("ovr_first_write", int'(overrun), 0);
    set_lane(0, 0, 0, 6);
    step();
    check("ovr_set", int'(overrun), 1);
    set_lane(1, 0, 1, -9); set_lane(2, 1, 0, -9); set_lane(3, 1, 1, -9);
    step();
    step();
    check("ovr_window_data", int'(out_data), 6);
    check("ovr_sticky", int'(overrun), 1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clr_overrun", int'(overrun), 0);
    check("clr_idle", int'(idle), 1);
    check("clr_out_valid", int'(out_valid), 0);

    // Reset mid-flight with two FIFO entries.
    write_row(0, 1, 1, 1, 1);
    write_row(1, 2, 2, 2, 2);
    repeat (3) step();
    check("rmf_two_valid", int'(out_valid), 1);
    #2 reset_n = 1'b0;
    #1;
    check("rmf_valid_low", int'(out_valid), 0);
    check("rmf_idle", int'(idle), 1);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) step();
    check("rmf_no_stale", int'(out_valid), 0);
    check("rmf_idle_after", int'(idle), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pool_unit.md
# pool_unit

Parametrised successor to the tile max-pool stage: collects requantised int8 samples from the SA_N systolic-array columns into an SA_N×SA_N scratch tile, detects completed FILTER_H×FILTER_W windows and reduces each by max or rounded average. Results are buffered in a first-word-fall-through output FIFO behind a valid/ready handshake, so the downstream writer can stall without losing windows. It sits between the requant units and the activation write-back path, one instance per output stream.

## Interface
- SA_N, 4: tile dimension / input lanes; power of 2, ≥ FILTER_H, FILTER_W
- MAX_N, 512: max matrix dimension
- N_BITS, $clog2(MAX_N+1): coordinate width
- FILTER_H, 2: window height; power of 2, divides SA_N
- FILTER_W, 2: window width; power of 2, divides SA_N
- FIFO_DEPTH, 4: output FIFO entries; ≥ 2, power of 2
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- clear  in  1  synchronous flush of scratch valid bits, FIFO and overrun
- pool_mode  in  1  0 = max, 1 = average; stable while idle = 0
- pos_row, pos_col  in  N_BITS each  tile base coordinate; stable while idle = 0
- in_valid  in  1 [SA_N]  lane sample valid
- in_row, in_col  in  N_BITS [SA_N]  absolute sample coordinate
- in_data  in  int8_t [SA_N]  sample
- out_valid  out  1  FIFO head valid
- out_ready  in  1  downstream accepts head
- out_row, out_col  out  N_BITS  absolute coord of window's top-left sample
- out_data  out  int8_t  pooled value
- overrun  out  1  sticky: a sample hit an already-valid cell
- idle  out  1  no valid scratch cell and FIFO empty

## Operation
- Lane write: cell index = low $clog2(SA_N) bits of (in_row−pos_row), (in_col−pos_col); sets data and valid bit. Lanes are expected to hit distinct cells; same-cell collisions among lanes: highest lane index wins.
- Window scan (combinational on registered valid map): first window with all H×W cells valid, row-major priority (window row, then window col).
- emit = window found AND (FIFO not full OR out_ready with out_valid). On emit: push {row, col, data}, clear that window's valid bits.
- Max mode: signed max of H×W cells.
- Average mode: S = log2(H·W); sum in 8+S-bit signed; data = (sum + 2^(S−1)) >>> S (round half up, arithmetic shift); result always in int8 range, no saturation.
- out_row = pos_row + FILTER_H·wr, out_col = pos_col + FILTER_W·wc, truncated to N_BITS.
- Pop when out_valid AND out_ready. Push and pop in same cycle legal at any fill level, including full.
- Overrun: write to a cell whose valid bit is 1 (and not being cleared by this cycle's emit) sets overrun; data overwritten, bit stays 1. Write to a cell of the window emitting this cycle: emitted value uses old data; cell ends valid with new data; overrun set.
- clear: valid map, FIFO pointers/count, overrun → 0; writes and emit in that cycle are discarded. clear has priority over everything except reset_n.
- idle = no valid bit set AND FIFO empty.

## Timing
- Reset (reset_n low, async): valid map 0, FIFO empty, out_valid 0, out_row/out_col/out_data 0, overrun 0, idle 1. Scratch data not reset.
- Latency: sample with in_valid at edge E → valid bit after E → window pushed at E+1 → out_valid high after E+1 (FIFO empty case): 2 cycles.
- At most one window emitted per cycle; remaining ready windows wait.
- FIFO full and out_ready low: no emit, window stays valid in scratch (no loss).
- reset_n asserted mid-operation: all pending windows and FIFO contents lost, outputs to reset values immediately.

## Test plan
- Max, 2×2, pos=(0,0): write cell (0,0..3)=1,5,-3,2 then row 1=7,-8,4,4 → two outputs: (0,0)=7, (0,2)=4; out_valid 2 cycles after row-1 write; idle returns 1.
- Average, 2×2: window {-1,-1,-1,-2} → -1; {127,127,127,127} → 127; {1,2,1,2} → 2; {-128×4} → -128.
- Backpressure: FIFO_DEPTH=4, fill all four 2×2 windows of a 4×4 tile with out_ready=0 → 4 entries, no loss; fill next tile windows with out_ready=0 → no emit, windows held; raise out_ready → all emitted in row-major order, one per cycle.
- Priority: windows (1,1) and (0,1) complete same cycle → (0,1) emitted first, (1,1) next cycle.
- Overrun: write (0,0)=3 twice before window completes → overrun=1, window uses second value; clear → overrun=0, idle=1.
- Reset mid-flight: 2 entries in FIFO, reset_n low one cycle → out_valid=0, idle=1, no stale output after release.
